// File: rtl/battleship_pkg.sv
// Shared types for the Battleship controller and VGAMain colour decode.
// Cell codes, cursor overlay bit, board geometry, FSM states, coordinates.
package battleship_pkg;

  localparam int ROWS  = 5;
  localparam int COLS  = 5;
  localparam int NCELL = ROWS * COLS;

  // Bit 3 of a displayed cell marks the cursor; never stored in a board.
  localparam int CELL_CURSOR = 3;

  typedef enum logic [3:0] {
    CELL_EMPTY = 4'd0,
    CELL_SHIP  = 4'd1,
    CELL_MISS  = 4'd2,
    CELL_HIT   = 4'd3
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AIM,
    ST_RESOLVE,
    ST_OVER
  } state_t;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } coord_t;

  function automatic logic [4:0] popcount(
    input logic [NCELL-1:0] m
  );
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NCELL; i++)
      n = n + 5'(m[i]);
    return n;
  endfunction

endpackage

// File: rtl/battleship_board.sv
// One player's 5x5 board: map load, single shot write port, hit tracking.
// Ports: clk, rst, load+map, shot+pos, cells (stored codes), last_ship.
module battleship_board
  import battleship_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [NCELL-1:0]              map,
  input  logic                          shot,
  input  coord_t                        pos,
  output logic [ROWS-1:0][COLS-1:0][3:0] cells,
  output logic                          last_ship
);

  logic [4:0] hits;
  logic [4:0] total;

  // High when one more hit sinks the final ship on this board.
  assign last_ship = (total != '0) &&
                     ((hits + 5'd1) == total);

  always_ff @(posedge clk) begin
    if (rst) begin
      cells <= '0;
      hits  <= '0;
      total <= '0;
    end else if (load) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          cells[r][c] <= map[r*COLS+c] ?
                         CELL_SHIP : CELL_EMPTY;
      hits  <= '0;
      total <= popcount(map);
    end else if (shot) begin
      if (cells[pos.row][pos.col] == CELL_SHIP) begin
        cells[pos.row][pos.col] <= CELL_HIT;
        hits <= hits + 5'd1;
      end else if (cells[pos.row][pos.col] == CELL_EMPTY) begin
        cells[pos.row][pos.col] <= CELL_MISS;
      end
    end
  end

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship turn sequencer: cursor, shots, turn timer, game over, display.
// Ports: clk, rst, start, ship maps, move/fire buttons -> disp_matrix, status pulses.
module battleship_game_ctrl
  import battleship_pkg::*;
#(
  parameter int TURN_TICKS = 500_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NCELL-1:0]              ship_map_p0,
  input  logic [NCELL-1:0]              ship_map_p1,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic                          btn_left,
  input  logic                          btn_right,
  input  logic                          btn_fire,
  output logic [ROWS-1:0][COLS-1:0][3:0] disp_matrix,
  output logic                          active_player,
  output logic                          shot_hit,
  output logic                          shot_miss,
  output logic                          shot_reject,
  output logic                          turn_timeout,
  output logic                          game_over,
  output logic                          winner
);

  localparam int TW = (TURN_TICKS > 0) ?
                      $clog2(TURN_TICKS + 1) : 1;

  state_t      st;
  coord_t      cur;
  coord_t      tgt;
  coord_t      mv;
  logic [TW-1:0] tmr;

  logic [ROWS-1:0][COLS-1:0][3:0] cells0;
  logic [ROWS-1:0][COLS-1:0][3:0] cells1;
  logic [ROWS-1:0][COLS-1:0][3:0] tcells;
  logic [ROWS-1:0][COLS-1:0][3:0] lcells;
  logic [ROWS-1:0][COLS-1:0][3:0] disp_d;

  logic       last0, last1, tlast;
  logic       ld, we0, we1;
  logic [3:0] tcur, tres;
  logic       fresh, expire, res_ship;

  assign ld = start &&
              (st == ST_IDLE || st == ST_OVER) &&
              (|ship_map_p0) && (|ship_map_p1);

  // The shot lands on the opponent's board.
  assign we0 = (st == ST_RESOLVE) && active_player;
  assign we1 = (st == ST_RESOLVE) && !active_player;

  assign tcells = active_player ? cells0 : cells1;
  assign tlast  = active_player ? last0 : last1;
  assign lcells = winner ? cells0 : cells1;

  assign tcur  = tcells[cur.row][cur.col];
  assign fresh = (tcur == CELL_EMPTY) ||
                 (tcur == CELL_SHIP);

  assign tres     = tcells[tgt.row][tgt.col];
  assign res_ship = (tres == CELL_SHIP);

  assign expire = (TURN_TICKS != 0) &&
                  (tmr == TW'(TURN_TICKS - 1));

  battleship_board u_b0 (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .map       (ship_map_p0),
    .shot      (we0),
    .pos       (tgt),
    .cells     (cells0),
    .last_ship (last0)
  );

  battleship_board u_b1 (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .map       (ship_map_p1),
    .shot      (we1),
    .pos       (tgt),
    .cells     (cells1),
    .last_ship (last1)
  );

  // Several buttons may be pressed at once; first match wins.
  always_comb begin
    mv = cur;
    priority case (1'b1)
      btn_up:
        mv.row = (cur.row == 3'd0) ?
                 3'(ROWS - 1) : cur.row - 3'd1;
      btn_down:
        mv.row = (cur.row == 3'(ROWS - 1)) ?
                 3'd0 : cur.row + 3'd1;
      btn_left:
        mv.col = (cur.col == 3'd0) ?
                 3'(COLS - 1) : cur.col - 3'd1;
      btn_right:
        mv.col = (cur.col == 3'(COLS - 1)) ?
                 3'd0 : cur.col + 3'd1;
      default: ;
    endcase
  end

  always_comb begin
    disp_d = '0;
    unique case (st)
      ST_AIM, ST_RESOLVE: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) begin
            disp_d[r][c] =
              (tcells[r][c] == CELL_SHIP) ?
              4'(CELL_EMPTY) : tcells[r][c];
            if (st == ST_AIM &&
                3'(r) == cur.row &&
                3'(c) == cur.col)
              disp_d[r][c][CELL_CURSOR] = 1'b1;
          end
      end
      ST_OVER: disp_d = lcells;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= ST_IDLE;
      cur           <= '0;
      tgt           <= '0;
      tmr           <= '0;
      active_player <= 1'b0;
      shot_hit      <= 1'b0;
      shot_miss     <= 1'b0;
      shot_reject   <= 1'b0;
      turn_timeout  <= 1'b0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
      disp_matrix   <= '0;
    end else begin
      shot_hit     <= 1'b0;
      shot_miss    <= 1'b0;
      shot_reject  <= 1'b0;
      turn_timeout <= 1'b0;
      disp_matrix  <= disp_d;
      unique case (st)
        ST_IDLE, ST_OVER: begin
          if (ld) begin
            active_player <= 1'b0;
            cur           <= '0;
            tmr           <= '0;
            game_over     <= 1'b0;
            st            <= ST_AIM;
          end
        end
        ST_AIM: begin
          if (btn_fire && fresh) begin
            tgt <= cur;
            st  <= ST_RESOLVE;
          end else begin
            if (btn_fire)
              shot_reject <= 1'b1;
            if (expire) begin
              turn_timeout  <= 1'b1;
              active_player <= ~active_player;
              cur           <= '0;
              tmr           <= '0;
            end else begin
              tmr <= tmr + TW'(1);
              if (!btn_fire)
                cur <= mv;
            end
          end
        end
        ST_RESOLVE: begin
          shot_hit  <= res_ship;
          shot_miss <= ~res_ship;
          if (res_ship && tlast) begin
            game_over <= 1'b1;
            winner    <= active_player;
            st        <= ST_OVER;
          end else begin
            active_player <= ~active_player;
            cur           <= '0;
            tmr           <= '0;
            st            <= ST_AIM;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
